// File: rtl/multi_channel_sync_fifo.sv
// NUM_CH independent FIFO queues sharing one memory, one write and one read per cycle.
// Per-channel status, runtime thresholds, per-channel clear, sticky error flags, optional registered read.
module multi_channel_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int NUM_CH     = 4,
  parameter int REG_OUT    = 0,
  localparam int AW  = $clog2(DEPTH),
  localparam int CW  = AW + 1,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH-1:0]      clear,
  input  logic                   wen,
  input  logic [CHW-1:0]         wch,
  input  logic [DATA_WIDTH-1:0]  wdata,
  input  logic                   ren,
  input  logic [CHW-1:0]         rch,
  output logic [DATA_WIDTH-1:0]  rdata,
  output logic                   rvalid,
  input  logic [CW-1:0]          afull_thr,
  input  logic [CW-1:0]          aempty_thr,
  output logic [NUM_CH-1:0]      empty,
  output logic [NUM_CH-1:0]      full,
  output logic [NUM_CH-1:0]      afull,
  output logic [NUM_CH-1:0]      aempty,
  output logic [NUM_CH-1:0]      overflow,
  output logic [NUM_CH-1:0]      underflow,
  output logic [NUM_CH*CW-1:0]   count
);

  localparam logic [CHW:0] NCH = (CHW+1)'(NUM_CH);

  logic [DATA_WIDTH-1:0] r_mem   [NUM_CH*DEPTH];
  logic [AW-1:0]         r_wptr  [NUM_CH];
  logic [AW-1:0]         r_rptr  [NUM_CH];
  logic [CW-1:0]         r_count [NUM_CH];
  logic [NUM_CH-1:0]     r_ovf, r_udf;

  logic                  w_wch_ok, w_rch_ok;
  logic [NUM_CH-1:0]     w_wsel, w_rsel, w_wr, w_rd;
  logic [CHW+AW-1:0]     w_waddr, w_raddr;
  logic [DATA_WIDTH-1:0] w_head;

  assign w_wch_ok = ({1'b0, wch} < NCH);
  assign w_rch_ok = ({1'b0, rch} < NCH);
  assign w_wsel   = w_wch_ok ? (NUM_CH'(1) << wch) : '0;
  assign w_rsel   = w_rch_ok ? (NUM_CH'(1) << rch) : '0;
  assign w_waddr  = w_wch_ok ? {wch, r_wptr[wch]} : '0;
  assign w_raddr  = w_rch_ok ? {rch, r_rptr[rch]} : '0;
  assign w_head   = r_mem[w_raddr];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    empty  = '0;
    full   = '0;
    afull  = '0;
    aempty = '0;
    count  = '0;
    w_wr   = '0;
    w_rd   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      empty[c]          = (r_count[c] == '0);
      full[c]           = (r_count[c] == CW'(DEPTH));
      afull[c]          = (r_count[c] >= afull_thr);
      aempty[c]         = (r_count[c] <= aempty_thr);
      count[c*CW +: CW] = r_count[c];
      w_wr[c]           = wen & w_wsel[c] & ~full[c]  & ~clear[c];
      w_rd[c]           = ren & w_rsel[c] & ~empty[c] & ~clear[c];
    end
  end

  assign overflow  = r_ovf;
  assign underflow = r_udf;

  // NOTE: the memory is deliberately reset here because reset must return every head word to zero;
  // per-channel clear leaves it untouched, only the pointers move.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH*DEPTH; i++) r_mem[i] <= '0;
    end else if (|w_wr) begin
      // NOTE: sequential state is only ever assigned with non-blocking assignments.
      r_mem[w_waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= '0;
      r_udf <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_wptr[c]  <= '0;
        r_rptr[c]  <= '0;
        r_count[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (clear[c]) begin
          r_wptr[c]  <= '0;
          r_rptr[c]  <= '0;
          r_count[c] <= '0;
          r_ovf[c]   <= 1'b0;
          r_udf[c]   <= 1'b0;
        end else begin
          if (w_wr[c]) r_wptr[c] <= r_wptr[c] + AW'(1);
          if (w_rd[c]) r_rptr[c] <= r_rptr[c] + AW'(1);
          if (w_wr[c] && !w_rd[c])      r_count[c] <= r_count[c] + CW'(1);
          else if (w_rd[c] && !w_wr[c]) r_count[c] <= r_count[c] - CW'(1);
          if (wen && w_wsel[c] && full[c])  r_ovf[c] <= 1'b1;
          if (ren && w_rsel[c] && empty[c]) r_udf[c] <= 1'b1;
        end
      end
    end
  end

  if (REG_OUT != 0) begin : g_reg_out
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_rdata  <= '0;
        r_rvalid <= 1'b0;
      end else begin
        r_rvalid <= |w_rd;
        if (|w_rd) r_rdata <= w_head;
      end
    end
    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
  end else begin : g_comb_out
    assign rdata  = w_head;
    assign rvalid = |(w_rsel & ~empty);
  end

endmodule

// File: tb/tb_multi_channel_sync_fifo.sv
// Scoreboard bench: show-ahead and registered-output instances share stimulus,
// per-channel expected-data queues and a small occupancy/flag model.
module tb_multi_channel_sync_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  clear;
  logic        wen, ren;
  logic [1:0]  wch, rch;
  logic [7:0]  wdata;
  logic [4:0]  afull_thr, aempty_thr;

  logic [7:0]  rdata0, rdata1;
  logic        rvalid0, rvalid1;
  logic [3:0]  empty0, full0, afull0, aempty0, ovf0, udf0;
  logic [3:0]  empty1, full1, afull1, aempty1, ovf1, udf1;
  logic [19:0] count0, count1;

  int          n_cmp = 0;
  int          n_err = 0;

  int          m_cnt [4];
  logic [3:0]  m_ovf, m_udf;
  logic [7:0]  exp_q [4][$];

  always #5 clk = ~clk;

  multi_channel_sync_fifo #(.DATA_WIDTH(8), .DEPTH(16), .NUM_CH(4), .REG_OUT(0)) dut0 (
    .clk(clk), .rst(rst), .clear(clear), .wen(wen), .wch(wch), .wdata(wdata),
    .ren(ren), .rch(rch), .rdata(rdata0), .rvalid(rvalid0),
    .afull_thr(afull_thr), .aempty_thr(aempty_thr),
    .empty(empty0), .full(full0), .afull(afull0), .aempty(aempty0),
    .overflow(ovf0), .underflow(udf0), .count(count0)
  );

  multi_channel_sync_fifo #(.DATA_WIDTH(8), .DEPTH(16), .NUM_CH(4), .REG_OUT(1)) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .wen(wen), .wch(wch), .wdata(wdata),
    .ren(ren), .rch(rch), .rdata(rdata1), .rvalid(rvalid1),
    .afull_thr(afull_thr), .aempty_thr(aempty_thr),
    .empty(empty1), .full(full1), .afull(afull1), .aempty(aempty1),
    .overflow(ovf1), .underflow(udf1), .count(count1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_status();
    logic [19:0] ec;
    logic [3:0]  em, fu, af, ae;
    for (int c = 0; c < 4; c++) begin
      ec[c*5 +: 5] = 5'(m_cnt[c]);
      em[c] = (m_cnt[c] == 0);
      fu[c] = (m_cnt[c] == 16);
      af[c] = (m_cnt[c] >= int'(afull_thr));
      ae[c] = (m_cnt[c] <= int'(aempty_thr));
    end
    check("count", count0, ec);
    check("count_reg_inst", count1, ec);
    check("empty", empty0, em);
    check("full", full0, fu);
    check("afull", afull0, af);
    check("aempty", aempty0, ae);
    check("overflow", ovf0, m_ovf);
    check("underflow", udf0, m_udf);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_cnt[c] = 0;
      exp_q[c].delete();
    end
    m_ovf = '0;
    m_udf = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; wen = 1'b0; ren = 1'b0; clear = '0; wch = '0; rch = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_status();
    check("rst_rvalid_reg", rvalid1, 1'b0);
    check("rst_rdata_reg", rdata1, 8'h00);
    check("rst_rdata_comb", rdata0, 8'h00);
  endtask

  // One clock of stimulus; inputs applied just after an edge, outputs sampled 1 ns later
  // (show-ahead path) and again 1 ns after the following edge (registered path, status).
  task automatic cycle(input logic we, input logic [1:0] wc, input logic [7:0] wd,
                       input logic re, input logic [1:0] rc, input logic [3:0] clr);
    logic       acc_w, acc_r;
    logic [7:0] hd;
    hd = '0;
    wen = we; wch = wc; wdata = wd; ren = re; rch = rc; clear = clr;
    #1;
    acc_w = we && !clr[wc] && (m_cnt[wc] < 16);
    acc_r = re && !clr[rc] && (m_cnt[rc] > 0);
    if (re) check("rvalid_comb", rvalid0, (m_cnt[rc] != 0));
    if (acc_r) begin
      hd = exp_q[rc].pop_front();
      check("rdata_comb", rdata0, hd);
    end
    if (we && !clr[wc] && m_cnt[wc] == 16) m_ovf[wc] = 1'b1;
    if (re && !clr[rc] && m_cnt[rc] == 0)  m_udf[rc] = 1'b1;
    if (acc_w) begin
      exp_q[wc].push_back(wd);
      m_cnt[wc]++;
    end
    if (acc_r) m_cnt[rc]--;
    for (int c = 0; c < 4; c++) begin
      if (clr[c]) begin
        exp_q[c].delete();
        m_cnt[c] = 0;
        m_ovf[c] = 1'b0;
        m_udf[c] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("rvalid_reg", rvalid1, acc_r);
    if (acc_r) check("rdata_reg", rdata1, hd);
    wen = 1'b0; ren = 1'b0; clear = '0;
    check_status();
  endtask

  initial begin
    afull_thr  = 5'd16;
    aempty_thr = 5'd0;
    do_reset();

    // afull follows the threshold combinationally; threshold 0 makes every channel almost-full.
    afull_thr = 5'd0;
    #1;
    check("afull_thr0", afull0, 4'hF);
    afull_thr = 5'd16;
    #1;
    check("afull_thr16", afull0, 4'h0);

    // Fill ch2 plus one extra write, then drain and underflow it.
    for (int i = 0; i < 16; i++) cycle(1'b1, 2'd2, 8'(i), 1'b0, 2'd0, 4'b0);
    cycle(1'b1, 2'd2, 8'hAA, 1'b0, 2'd0, 4'b0);
    check("fill_full2", full0[2], 1'b1);
    check("fill_ovf2", ovf0[2], 1'b1);
    check("fill_cnt2", count0[10 +: 5], 5'd16);
    for (int i = 0; i < 16; i++) cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 4'b0);
    check("drain_empty2", empty0[2], 1'b1);
    cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 4'b0);
    check("drain_udf2", udf0[2], 1'b1);

    // Wrap-around on ch0: 40 writes and 40 reads with occupancy held at 1..2.
    cycle(1'b1, 2'd0, 8'h40, 1'b0, 2'd0, 4'b0);
    cycle(1'b1, 2'd0, 8'h41, 1'b0, 2'd0, 4'b0);
    for (int i = 2; i < 40; i++) cycle(1'b1, 2'd0, 8'(8'h40 + i), 1'b1, 2'd0, 4'b0);
    cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 4'b0);
    cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 4'b0);
    check("wrap_cnt0", count0[0 +: 5], 5'd0);

    // Simultaneous access on one channel: mid-occupancy, full, and empty.
    for (int i = 0; i < 5; i++) cycle(1'b1, 2'd1, 8'(8'h10 + i), 1'b0, 2'd0, 4'b0);
    cycle(1'b1, 2'd1, 8'h15, 1'b1, 2'd1, 4'b0);
    check("rw_same_cnt1", count0[5 +: 5], 5'd5);
    for (int i = 0; i < 16; i++) cycle(1'b1, 2'd3, 8'(8'h30 + i), 1'b0, 2'd0, 4'b0);
    cycle(1'b1, 2'd3, 8'hFF, 1'b1, 2'd3, 4'b0);
    check("rw_full_cnt3", count0[15 +: 5], 5'd15);
    check("rw_full_ovf3", ovf0[3], 1'b1);
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 4'b0100);
    cycle(1'b1, 2'd2, 8'h77, 1'b1, 2'd2, 4'b0);
    check("rw_empty_cnt2", count0[10 +: 5], 5'd1);
    check("rw_empty_udf2", udf0[2], 1'b1);

    // Per-channel clear beats a same-cycle write and leaves other channels alone.
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 4'b1111);
    cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 4'b0);
    for (int i = 0; i < 7; i++) cycle(1'b1, 2'd1, 8'(8'h50 + i), 1'b0, 2'd0, 4'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'd3, 8'(8'h60 + i), 1'b0, 2'd0, 4'b0);
    cycle(1'b1, 2'd1, 8'hEE, 1'b0, 2'd0, 4'b0010);
    check("clr_cnt1", count0[5 +: 5], 5'd0);
    check("clr_udf1", udf0[1], 1'b0);
    check("clr_cnt3", count0[15 +: 5], 5'd4);
    for (int i = 0; i < 4; i++) cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 4'b0);

    // Thresholds: fill ch0 one word per cycle; status check follows every step.
    afull_thr  = 5'd12;
    aempty_thr = 5'd2;
    for (int i = 0; i < 16; i++) cycle(1'b1, 2'd0, 8'(8'h80 + i), 1'b0, 2'd0, 4'b0);
    // Registered port: back-to-back reads, an idle gap, then a lone read.
    cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 4'b0);
    cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 4'b0);
    cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 4'b0);
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 4'b0);
    cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 4'b0);

    // Reset in the middle of traffic.
    cycle(1'b1, 2'd1, 8'h99, 1'b1, 2'd0, 4'b0);
    cycle(1'b1, 2'd3, 8'h9A, 1'b1, 2'd2, 4'b0);
    do_reset();
    cycle(1'b1, 2'd0, 8'h5A, 1'b0, 2'd0, 4'b0);
    cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 4'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
